// File: rtl/alu_stage_pkg.sv
// alu_stage_pkg: shared width default, FSM state type and op encoding for the ALU stage
package alu_stage_pkg;

    localparam int ALU_WIDTH = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // OUT owns its own bit so strobes decoded from it never see a multi-bit transition
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        OUT  = 2'b10
    } aluState_e;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: combinational WIDTH-bit add/subtract with carry-out (subtract carry = no borrow)
module alu_addsub
    import alu_stage_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             op,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut
);

    logic             isSub;
    logic [WIDTH-1:0] opBEff;

    // subtract is A + ~B with the +1 entering as carry-in; carry is bit WIDTH of the sum
    always_comb begin
        isSub             = (op == OP_SUB);
        opBEff            = isSub ? ~opB : opB;
        {carryOut, sum}   = {1'b0, opA} + {1'b0, opBEff} + {{WIDTH{1'b0}}, isSub};
    end

endmodule

// File: rtl/alu_stage.sv
// alu_stage: three-state (IDLE/EXEC/OUT) add/subtract stage driving a shared bus and write-back strobe
module alu_stage
    import alu_stage_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             MainClock,
    input  logic             ClearB,
    input  logic [WIDTH-1:0] AluA,
    input  logic [WIDTH-1:0] AluB,
    input  logic             Sub,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic             EnableOut,
    output logic [WIDTH-1:0] BusOut,
    output logic             LatchA,
    output logic [WIDTH-1:0] Result,
    output logic             CarryFlag,
    output logic             ZeroFlag
);

    aluState_e        state;
    aluState_e        nextState;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             opSub;
    logic [WIDTH-1:0] aluSum;
    logic             aluCarry;
    logic             busyReg;
    logic             outReg;
    logic [WIDTH-1:0] busReg;
    logic [WIDTH-1:0] resultReg;
    logic             carryReg;
    logic             zeroReg;

    alu_addsub #(.WIDTH(WIDTH)) addSub (
        .opA      (opA),
        .opB      (opB),
        .op       (opSub),
        .sum      (aluSum),
        .carryOut (aluCarry)
    );

    // state register
    always_ff @(posedge MainClock or negedge ClearB) begin
        if (!ClearB) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // next state: Start only matters in IDLE; EXEC and OUT advance unconditionally
    always_comb begin
        nextState = IDLE;
        nextState = (state == IDLE) ? (Start ? EXEC : IDLE) :
                    (state == EXEC) ? OUT : IDLE;
    end

    // operand capture on the accepting edge, so later input changes cannot disturb the op
    always_ff @(posedge MainClock or negedge ClearB) begin
        if (!ClearB) begin
            opA   <= '0;
            opB   <= '0;
            opSub <= OP_ADD;
        end else if (state == IDLE && Start) begin
            opA   <= AluA;
            opB   <= AluB;
            opSub <= Sub;
        end
    end

    // result and flags load on the EXEC-to-OUT edge and hold otherwise
    always_ff @(posedge MainClock or negedge ClearB) begin
        if (!ClearB) begin
            resultReg <= '0;
            carryReg  <= 1'b0;
            zeroReg   <= 1'b0;
        end else if (state == EXEC) begin
            resultReg <= aluSum;
            carryReg  <= aluCarry;
            zeroReg   <= (aluSum == '0);
        end
    end

    // handshake strobes and bus value registered from next state so they come straight off flops
    always_ff @(posedge MainClock or negedge ClearB) begin
        if (!ClearB) begin
            busyReg <= 1'b0;
            outReg  <= 1'b0;
            busReg  <= '0;
        end else begin
            busyReg <= (nextState != IDLE);
            outReg  <= (nextState == OUT);
            busReg  <= (nextState == OUT) ? aluSum : '0;
        end
    end

    assign Busy      = busyReg;
    assign Done      = outReg;
    assign EnableOut = outReg;
    assign LatchA    = outReg;
    assign BusOut    = busReg;
    assign Result    = resultReg;
    assign CarryFlag = carryReg;
    assign ZeroFlag  = zeroReg;

endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: directed vectors plus a per-cycle arithmetic reference model for alu_stage
module tb_alu_stage;

    logic       MainClock = 1'b0;
    logic       ClearB;
    logic [3:0] AluA;
    logic [3:0] AluB;
    logic       Sub;
    logic       Start;
    logic       Busy;
    logic       Done;
    logic       EnableOut;
    logic [3:0] BusOut;
    logic       LatchA;
    logic [3:0] Result;
    logic       CarryFlag;
    logic       ZeroFlag;

    int total = 0;
    int bad = 0;
    int doneCount = 0;

    // reference model: edges since the accepted Start (-1 = idle), arithmetic on plain integers
    int stage = -1;
    int mRes = 0;
    int mC = 0;
    int mZ = 0;
    int ma = 0;
    int mb = 0;
    int msub = 0;

    alu_stage #(.WIDTH(4)) dut (
        .MainClock (MainClock),
        .ClearB    (ClearB),
        .AluA      (AluA),
        .AluB      (AluB),
        .Sub       (Sub),
        .Start     (Start),
        .Busy      (Busy),
        .Done      (Done),
        .EnableOut (EnableOut),
        .BusOut    (BusOut),
        .LatchA    (LatchA),
        .Result    (Result),
        .CarryFlag (CarryFlag),
        .ZeroFlag  (ZeroFlag)
    );

    always #5 MainClock = ~MainClock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge MainClock or negedge ClearB) begin
        if (!ClearB) begin
            stage = -1;
            mRes  = 0;
            mC    = 0;
            mZ    = 0;
        end else if (stage < 0 && Start) begin
            ma    = int'(AluA);
            mb    = int'(AluB);
            msub  = int'(Sub);
            stage = 0;
        end else if (stage == 0) begin
            if (msub != 0) begin
                mRes = (ma - mb + 16) % 16;
                mC   = (ma >= mb) ? 1 : 0;
            end else begin
                mRes = (ma + mb) % 16;
                mC   = (ma + mb >= 16) ? 1 : 0;
            end
            mZ    = (mRes == 0) ? 1 : 0;
            stage = 1;
        end else begin
            stage = -1;
        end
    end

    always @(negedge MainClock) begin
        chk("mBusy",   32'(Busy),      32'(stage >= 0));
        chk("mDone",   32'(Done),      32'(stage == 1));
        chk("mEnable", 32'(EnableOut), 32'(stage == 1));
        chk("mLatchA", 32'(LatchA),    32'(stage == 1));
        chk("mBusOut", 32'(BusOut),    (stage == 1) ? mRes : 0);
        chk("mResult", 32'(Result),    mRes);
        chk("mCarry",  32'(CarryFlag), mC);
        chk("mZero",   32'(ZeroFlag),  mZ);
        if (Done) doneCount++;
    end

    task automatic checkAllZero(input string tag);
        chk({tag, "Busy"},   32'(Busy),      0);
        chk({tag, "Done"},   32'(Done),      0);
        chk({tag, "Enable"}, 32'(EnableOut), 0);
        chk({tag, "LatchA"}, 32'(LatchA),    0);
        chk({tag, "BusOut"}, 32'(BusOut),    0);
        chk({tag, "Result"}, 32'(Result),    0);
        chk({tag, "Carry"},  32'(CarryFlag), 0);
        chk({tag, "Zero"},   32'(ZeroFlag),  0);
    endtask

    task automatic doOp(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input int er, input int ec, input int ez);
        @(negedge MainClock);
        AluA  = a;
        AluB  = b;
        Sub   = s;
        Start = 1'b1;
        @(negedge MainClock);
        Start = 1'b0;
        chk("execBusy", 32'(Busy), 1);
        chk("execDone", 32'(Done), 0);
        AluA = 4'd0;
        AluB = 4'd0;
        Sub  = ~s;
        @(negedge MainClock);
        chk("outDone",   32'(Done),      1);
        chk("outEnable", 32'(EnableOut), 1);
        chk("outLatchA", 32'(LatchA),    1);
        chk("outBus",    32'(BusOut),    er);
        chk("outResult", 32'(Result),    er);
        chk("outCarry",  32'(CarryFlag), ec);
        chk("outZero",   32'(ZeroFlag),  ez);
        @(negedge MainClock);
        chk("idleDone",   32'(Done),   0);
        chk("idleBus",    32'(BusOut), 0);
        chk("heldResult", 32'(Result), er);
    endtask

    initial begin
        int d0;
        ClearB = 1'b0;
        AluA   = 4'd0;
        AluB   = 4'd0;
        Sub    = 1'b0;
        Start  = 1'b0;
        #1;
        checkAllZero("rst");
        repeat (2) @(negedge MainClock);
        #2 ClearB = 1'b1;

        doOp(4'd5, 4'd3, 1'b0, 8, 0, 0);
        doOp(4'd9, 4'd7, 1'b0, 0, 1, 1);
        doOp(4'd5, 4'd3, 1'b1, 2, 1, 0);
        doOp(4'd3, 4'd5, 1'b1, 14, 0, 0);
        doOp(4'd5, 4'd3, 1'b0, 8, 0, 0);

        // Start high across the accept, EXEC and OUT edges: one operation only
        d0 = doneCount;
        @(negedge MainClock);
        AluA  = 4'd1;
        AluB  = 4'd2;
        Sub   = 1'b0;
        Start = 1'b1;
        repeat (3) @(negedge MainClock);
        Start = 1'b0;
        repeat (3) @(negedge MainClock);
        chk("pulseDones",  32'(doneCount - d0), 1);
        chk("pulseResult", 32'(Result), 3);

        // Start held for 8 edges: accepts every third edge
        d0 = doneCount;
        AluA  = 4'd2;
        AluB  = 4'd1;
        Sub   = 1'b1;
        Start = 1'b1;
        repeat (8) @(negedge MainClock);
        Start = 1'b0;
        repeat (4) @(negedge MainClock);
        chk("heldDones",  32'(doneCount - d0), 3);
        chk("heldResult", 32'(Result), 1);

        // reset during EXEC aborts the op and clears everything at once
        @(negedge MainClock);
        AluA  = 4'd6;
        AluB  = 4'd6;
        Sub   = 1'b1;
        Start = 1'b1;
        @(negedge MainClock);
        Start = 1'b0;
        chk("preRstBusy", 32'(Busy), 1);
        d0 = doneCount;
        #2 ClearB = 1'b0;
        #1;
        checkAllZero("midRst");
        repeat (2) @(negedge MainClock);
        #2 ClearB = 1'b1;
        repeat (3) @(negedge MainClock);
        chk("rstNoDone", 32'(doneCount - d0), 0);
        doOp(4'd7, 4'd4, 1'b1, 3, 1, 0);

        repeat (2) @(negedge MainClock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
